// File: rtl/sap_exec_sequencer_if.sv
// rtl/sap_exec_sequencer_if.sv - fetch/execute handshake and datapath control bundle
interface sap_exec_sequencer_if #(
  parameter int OPW = 4,
  parameter int ADW = 4
);
  logic           start;
  logic [OPW-1:0] opcode;
  logic [ADW-1:0] operand;
  logic           flag_c;
  logic           flag_z;
  logic [ADW-1:0] operand_out;
  logic           ir_out;
  logic           mar_load;
  logic           ram_read;
  logic           ram_write;
  logic           a_load;
  logic           a_out;
  logic           b_load;
  logic           alu_out;
  logic           alu_sub;
  logic           flags_load;
  logic           pc_load;
  logic           out_load;
  logic [1:0]     step;
  logic           busy;
  logic           done;
  logic           halted;
  logic           illegal;

  modport master (
    output start, opcode, operand, flag_c, flag_z,
    input  operand_out, ir_out, mar_load, ram_read, ram_write, a_load, a_out,
           b_load, alu_out, alu_sub, flags_load, pc_load, out_load,
           step, busy, done, halted, illegal
  );

  modport slave (
    input  start, opcode, operand, flag_c, flag_z,
    output operand_out, ir_out, mar_load, ram_read, ram_write, a_load, a_out,
           b_load, alu_out, alu_sub, flags_load, pc_load, out_load,
           step, busy, done, halted, illegal
  );
endinterface

// File: rtl/sap_exec_sequencer.sv
// rtl/sap_exec_sequencer.sv - SAP execute-phase microsequencer with registered control word
module sap_exec_sequencer #(
  parameter int OPW = 4,
  parameter int ADW = 4
) (
  input logic                clk,
  input logic                rst,
  sap_exec_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HALT = 2'd2
  } state_t;

  // Control word bit positions, most significant first
  localparam int B_IR   = 15;
  localparam int B_MAR  = 14;
  localparam int B_RR   = 13;
  localparam int B_RW   = 12;
  localparam int B_AL   = 11;
  localparam int B_AO   = 10;
  localparam int B_BL   = 9;
  localparam int B_ALU  = 8;
  localparam int B_SUB  = 7;
  localparam int B_FL   = 6;
  localparam int B_PCL  = 5;
  localparam int B_OL   = 4;
  localparam int B_BUSY = 3;
  localparam int B_DONE = 2;
  localparam int B_HALT = 1;
  localparam int B_ILL  = 0;

  state_t         state, state_n;
  logic [1:0]     step_q, step_n;
  logic [OPW-1:0] opcode_q, op_n;
  logic [ADW-1:0] operand_q, opd_n;
  logic           c_q, z_q, c_n, z_n;
  logic           accept;
  logic [15:0]    ctl_q, ctl_n;
  logic [ADW-1:0] operand_out_q, operand_out_n;

  // Index of the final execute step for each opcode
  function automatic logic [1:0] last_step(input logic [OPW-1:0] op);
    case (op)
      OPW'(1), OPW'(4): last_step = 2'd1;
      OPW'(2), OPW'(3): last_step = 2'd2;
      default:          last_step = 2'd0;
    endcase
  endfunction

  assign accept = (state == IDLE) && bus.start;

  // The decode works on the values the registers are about to take, so that
  // controls appear registered in the same cycle as the state they belong to
  assign op_n  = accept ? bus.opcode  : opcode_q;
  assign opd_n = accept ? bus.operand : operand_q;
  assign c_n   = accept ? bus.flag_c  : c_q;
  assign z_n   = accept ? bus.flag_z  : z_q;

  // State register, instruction latch and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      step_q        <= 2'd0;
      opcode_q      <= '0;
      operand_q     <= '0;
      c_q           <= 1'b0;
      z_q           <= 1'b0;
      ctl_q         <= '0;
      operand_out_q <= '0;
    end else begin
      state         <= state_n;
      step_q        <= step_n;
      opcode_q      <= op_n;
      operand_q     <= opd_n;
      c_q           <= c_n;
      z_q           <= z_n;
      ctl_q         <= ctl_n;
      operand_out_q <= operand_out_n;
    end
  end

  // Next state: start only matters in IDLE; HALT is left only through rst
  always_comb begin
    state_n = state;
    step_n  = step_q;
    case (state)
      IDLE: begin
        step_n = 2'd0;
        if (bus.start) state_n = EXEC;
      end
      EXEC: begin
        if (step_q >= last_step(opcode_q)) begin
          step_n  = 2'd0;
          state_n = (opcode_q == OPW'(15)) ? HALT : IDLE;
        end else begin
          step_n = step_q + 2'd1;
        end
      end
      HALT: begin
        step_n = 2'd0;
      end
      default: begin
        state_n = IDLE;
        step_n  = 2'd0;
      end
    endcase
  end

  // Output decode of the upcoming (state, step, opcode) into the control word
  always_comb begin
    ctl_n         = '0;
    operand_out_n = '0;
    if (state_n == EXEC) begin
      ctl_n[B_BUSY] = 1'b1;
      ctl_n[B_DONE] = (step_n == last_step(op_n));
      case (op_n)
        OPW'(1): begin
          if (step_n == 2'd0) begin ctl_n[B_IR] = 1'b1; ctl_n[B_MAR] = 1'b1; end
          else begin ctl_n[B_RR] = 1'b1; ctl_n[B_AL] = 1'b1; end
        end
        OPW'(2), OPW'(3): begin
          if (step_n == 2'd0) begin
            ctl_n[B_IR] = 1'b1; ctl_n[B_MAR] = 1'b1;
          end else if (step_n == 2'd1) begin
            ctl_n[B_RR] = 1'b1; ctl_n[B_BL] = 1'b1;
          end else begin
            ctl_n[B_ALU] = 1'b1; ctl_n[B_AL] = 1'b1; ctl_n[B_FL] = 1'b1;
            ctl_n[B_SUB] = (op_n == OPW'(3));
          end
        end
        OPW'(4): begin
          if (step_n == 2'd0) begin ctl_n[B_IR] = 1'b1; ctl_n[B_MAR] = 1'b1; end
          else begin ctl_n[B_AO] = 1'b1; ctl_n[B_RW] = 1'b1; end
        end
        OPW'(5): begin
          ctl_n[B_IR] = 1'b1; ctl_n[B_AL] = 1'b1;
        end
        OPW'(6): begin
          ctl_n[B_IR] = 1'b1; ctl_n[B_PCL] = 1'b1;
        end
        OPW'(7): begin
          ctl_n[B_IR] = c_n; ctl_n[B_PCL] = c_n;
        end
        OPW'(8): begin
          ctl_n[B_IR] = z_n; ctl_n[B_PCL] = z_n;
        end
        OPW'(9), OPW'(10), OPW'(11), OPW'(12), OPW'(13): begin
          ctl_n[B_ILL] = 1'b1;
        end
        OPW'(14): begin
          ctl_n[B_AO] = 1'b1; ctl_n[B_OL] = 1'b1;
        end
        default: ;
      endcase
    end else if (state_n == HALT) begin
      ctl_n[B_HALT] = 1'b1;
    end
    if (ctl_n[B_IR]) operand_out_n = opd_n;
  end

  assign bus.ir_out      = ctl_q[B_IR];
  assign bus.mar_load    = ctl_q[B_MAR];
  assign bus.ram_read    = ctl_q[B_RR];
  assign bus.ram_write   = ctl_q[B_RW];
  assign bus.a_load      = ctl_q[B_AL];
  assign bus.a_out       = ctl_q[B_AO];
  assign bus.b_load      = ctl_q[B_BL];
  assign bus.alu_out     = ctl_q[B_ALU];
  assign bus.alu_sub     = ctl_q[B_SUB];
  assign bus.flags_load  = ctl_q[B_FL];
  assign bus.pc_load     = ctl_q[B_PCL];
  assign bus.out_load    = ctl_q[B_OL];
  assign bus.busy        = ctl_q[B_BUSY];
  assign bus.done        = ctl_q[B_DONE];
  assign bus.halted      = ctl_q[B_HALT];
  assign bus.illegal     = ctl_q[B_ILL];
  assign bus.step        = step_q;
  assign bus.operand_out = operand_out_q;

endmodule

// File: tb/tb_sap_exec_sequencer.sv
// tb/tb_sap_exec_sequencer.sv - directed self-checking bench for sap_exec_sequencer
module tb_sap_exec_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  sap_exec_sequencer_if #(.OPW(4), .ADW(4)) bus ();

  sap_exec_sequencer #(.OPW(4), .ADW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  localparam logic [15:0] IR  = 16'h8000, MAR = 16'h4000, RR  = 16'h2000, RW  = 16'h1000;
  localparam logic [15:0] AL  = 16'h0800, AO  = 16'h0400, BL  = 16'h0200, ALU = 16'h0100;
  localparam logic [15:0] SUB = 16'h0080, FL  = 16'h0040, PCL = 16'h0020, OL  = 16'h0010;
  localparam logic [15:0] BSY = 16'h0008, DN  = 16'h0004, HLT = 16'h0002, ILL = 16'h0001;

  logic [15:0] ctl;
  assign ctl = {bus.ir_out, bus.mar_load, bus.ram_read, bus.ram_write, bus.a_load, bus.a_out,
                bus.b_load, bus.alu_out, bus.alu_sub, bus.flags_load, bus.pc_load, bus.out_load,
                bus.busy, bus.done, bus.halted, bus.illegal};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] opd, input logic c, input logic z);
    bus.start = 1'b1; bus.opcode = op; bus.operand = opd; bus.flag_c = c; bus.flag_z = z;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.opcode = 4'h0; bus.operand = 4'h0; bus.flag_c = 1'b0; bus.flag_z = 1'b0;
    tick(); tick();
    chk("reset_ctl", ctl, 16'h0000);
    chk("reset_step", {14'd0, bus.step}, 16'd0);
    chk("reset_opd", {12'd0, bus.operand_out}, 16'd0);
    rst = 1'b0;
    tick();

    // LDA 0x9
    issue(4'h1, 4'h9, 1'b0, 1'b0);
    chk("lda_s0", ctl, IR | MAR | BSY);
    chk("lda_s0_opd", {12'd0, bus.operand_out}, 16'h0009);
    tick();
    chk("lda_s1", ctl, RR | AL | BSY | DN);
    chk("lda_s1_step", {14'd0, bus.step}, 16'd1);
    chk("lda_s1_opd", {12'd0, bus.operand_out}, 16'd0);
    tick();
    chk("lda_idle", ctl, 16'h0000);

    // SUB 0x3
    issue(4'h3, 4'h3, 1'b0, 1'b0);
    chk("sub_s0", ctl, IR | MAR | BSY);
    tick();
    chk("sub_s1", ctl, RR | BL | BSY);
    tick();
    chk("sub_s2", ctl, ALU | SUB | AL | FL | BSY | DN);
    chk("sub_s2_step", {14'd0, bus.step}, 16'd2);
    tick();
    chk("sub_idle", ctl, 16'h0000);
    chk("sub_idle_step", {14'd0, bus.step}, 16'd0);

    // JC taken, then flag dropped after accept
    issue(4'h7, 4'hA, 1'b1, 1'b0);
    bus.flag_c = 1'b0;
    chk("jc_taken", ctl, IR | PCL | BSY | DN);
    chk("jc_taken_opd", {12'd0, bus.operand_out}, 16'h000A);
    tick();
    chk("jc_idle", ctl, 16'h0000);
    // JC not taken, flag raised after accept
    issue(4'h7, 4'hA, 1'b0, 1'b0);
    bus.flag_c = 1'b1;
    chk("jc_not_taken", ctl, BSY | DN);
    chk("jc_not_taken_opd", {12'd0, bus.operand_out}, 16'd0);
    tick();
    // JZ taken on latched Z
    issue(4'h8, 4'h6, 1'b0, 1'b1);
    bus.flag_z = 1'b0;
    chk("jz_taken", ctl, IR | PCL | BSY | DN);
    chk("jz_taken_opd", {12'd0, bus.operand_out}, 16'h0006);
    tick();

    // ADD with a stray start during s1, then OUT right after done
    issue(4'h2, 4'h5, 1'b0, 1'b0);
    chk("add_s0", ctl, IR | MAR | BSY);
    tick();
    chk("add_s1", ctl, RR | BL | BSY);
    bus.start = 1'b1; bus.opcode = 4'hE;
    tick();
    bus.start = 1'b0;
    chk("add_s2_ignores_start", ctl, ALU | AL | FL | BSY | DN);
    tick();
    chk("add_idle", ctl, 16'h0000);
    issue(4'hE, 4'h0, 1'b0, 1'b0);
    chk("out_s0", ctl, AO | OL | BSY | DN);
    tick();
    chk("out_idle", ctl, 16'h0000);

    // Reset during ADD s1
    issue(4'h2, 4'h7, 1'b0, 1'b0);
    tick();
    chk("add2_s1", ctl, RR | BL | BSY);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_ctl", ctl, 16'h0000);
    chk("rst_mid_step", {14'd0, bus.step}, 16'd0);
    issue(4'h1, 4'h4, 1'b0, 1'b0);
    chk("lda2_s0", ctl, IR | MAR | BSY);
    chk("lda2_s0_opd", {12'd0, bus.operand_out}, 16'h0004);
    tick();
    chk("lda2_s1", ctl, RR | AL | BSY | DN);
    tick();

    // Illegal opcode 0xB
    issue(4'hB, 4'h1, 1'b0, 1'b0);
    chk("ill_s0", ctl, BSY | DN | ILL);
    tick();
    chk("ill_idle", ctl, 16'h0000);

    // STA
    issue(4'h4, 4'hC, 1'b0, 1'b0);
    chk("sta_s0", ctl, IR | MAR | BSY);
    tick();
    chk("sta_s1", ctl, AO | RW | BSY | DN);
    tick();

    // HLT then start with LDA
    issue(4'hF, 4'h0, 1'b0, 1'b0);
    chk("hlt_s0", ctl, BSY | DN);
    tick();
    chk("halted", ctl, HLT);
    issue(4'h1, 4'h2, 1'b0, 1'b0);
    chk("halted_ignores_start", ctl, HLT);
    tick();
    chk("halted_sticky", ctl, HLT);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("halt_cleared", ctl, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
